// File: rtl/midi_spi_pkg.sv
// Shared types and defaults for the MIDI router's SPI frame master.
package midi_spi_pkg;
    localparam int FRAME_BITS_DEFAULT = 48;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    typedef logic [47:0] spi_word_t;
endpackage

// File: rtl/spi_sck_prescaler.sv
// Divides clk into a mode-0 SCK: toggles every HALF_DIV cycles while enabled.
module spi_sck_prescaler #(
    parameter int HALF_DIV = 50
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    output logic tick,
    output logic sck
);
    localparam int CW = $clog2(HALF_DIV);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Disabling parks SCK low so it idles correctly between frames.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master for the 48-bit shiftreg chain: one word per frame,
// MSB first, full-duplex capture, followed by an enforced idle gap.
module spi_frame_master
    import midi_spi_pkg::*;
#(
    parameter int HALF_DIV   = 50,
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int GAP_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spi_sck,
    output logic                  spi_si,
    input  logic                  spi_so
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    state_t                state;
    logic [FRAME_BITS-2:0] tx_sr;   // bits still to send; current bit sits on spi_si
    logic [FRAME_BITS-1:0] rx_sr;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  tick;
    logic                  sck;

    spi_sck_prescaler #(.HALF_DIV(HALF_DIV)) u_presc (
        .clk    (clk),
        .nreset (nreset),
        .en     (state == SHIFT),
        .tick   (tick),
        .sck    (sck)
    );

    assign spi_sck = sck;

    // The gap is counted so that the next accept edge lands exactly GAP_CYCLES
    // after the last falling edge; GAP_CYCLES == 1 therefore returns straight to IDLE.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            spi_si   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sr    <= tx_data[FRAME_BITS-2:0];
                        spi_si   <= tx_data[FRAME_BITS-1];
                        rx_sr    <= '0;
                        bit_cnt  <= '0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sck) begin
                            rx_sr   <= {rx_sr[FRAME_BITS-2:0], spi_so};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (bit_cnt == BIT_LAST) begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                            spi_si   <= 1'b0;
                            gap_cnt  <= '0;
                            if (GAP_CYCLES > 1) begin
                                state <= GAP;
                            end else begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                tx_ready <= 1'b1;
                            end
                        end else begin
                            spi_si <= tx_sr[FRAME_BITS-2];
                            tx_sr  <= {tx_sr[FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
